serial_adder: RTL

- Bit-serial N-bit adder built around a single gate-level full adder cell.
- Operands are loaded in parallel, then shifted LSB-first through the cell, one bit per clock.
- The carry is held in a flip-flop between bit steps, and sum bits are collected in a shift register.
- Used wherever area matters more than latency; it is the sequential stage that drives the 1-bit cell and consumes its sum and carry outputs.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 16 +
 rtl/serial_adder.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Gate-level 1-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign cout = (a & b) | (cin & axb);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: operands shift LSB-first through one full adder cell.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVERFLOW_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_carry_in,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_s,
    output logic         o_carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic         o_overflow
`endif
);

    localparam int CNT_W = cnt_width(N);

    state_t           state, state_next;
    logic [N-1:0]     a_sr, b_sr;
    logic [N-2:0]     sum_sr;
    logic [N-1:0]     sum_next;
    logic             carry_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_s, fa_co;
    logic             accept, last_bit;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             msb_cin_q;
`endif

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign accept   = i_start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (bit_cnt == CNT_W'(N - 1));
    // Only N-1 sum bits need storing; the final bit comes straight from the cell.
    assign sum_next = {fa_s, sum_sr};
    assign o_busy   = (state == RUN);
    assign o_done   = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = i_start ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = i_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry_q     <= 1'b0;
            bit_cnt     <= '0;
            o_s         <= '0;
            o_carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            msb_cin_q   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr    <= i_a;
                b_sr    <= i_b;
                carry_q <= i_carry_in;
                bit_cnt <= '0;
            end else if (state == RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                sum_sr  <= sum_next[N-1:1];
                carry_q <= fa_co;
                bit_cnt <= bit_cnt + 1'b1;
                if (last_bit) begin
                    o_s         <= sum_next;
                    o_carry_out <= fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    msb_cin_q   <= carry_q;
`endif
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign o_overflow = msb_cin_q ^ o_carry_out;
`endif

endmodule
